// File: rtl/shift_l_int8_iter.sv
// Iterative signed left shifter: shifts A left by B[SHIFT_WIDTH-1:0], one bit per cycle, flagging signed overflow.
// Latency: out_valid rises B[SHIFT_WIDTH-1:0]+1 edges after the accepting edge (1..2^SHIFT_WIDTH).
// Backpressure: one operation in flight; in_ready is low until the result is taken with out_ready, and the result holds meanwhile.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready operand handshake; in_ready is high only in IDLE
//   A, B                operand and shift amount (only B[SHIFT_WIDTH-1:0] is used)
//   out_valid/out_ready result handshake; out_valid is high only in DONE
//   Y, ovf              shifted result and sticky signed-overflow flag, both registered
//   busy                high while the shift is iterating
module shift_l_int8_iter #(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHIFT_WIDTH-1:0] CNT_ONE = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_data;
    logic [WIDTH-1:0]       w_data_nxt;
    logic [SHIFT_WIDTH-1:0] r_count;
    logic [SHIFT_WIDTH-1:0] w_count_nxt;
    logic                   r_ovf;
    logic                   w_ovf_nxt;
    logic                   w_sign_change;

    // Shifting out a bit that differs from the new sign bit means the value
    // no longer fits; the top two bits are checked before each shift.
    assign w_sign_change = r_data[WIDTH-1] ^ r_data[WIDTH-2];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = A;
                    w_count_nxt = B[SHIFT_WIDTH-1:0];
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_count != '0) begin
                    w_data_nxt  = {r_data[WIDTH-2:0], 1'b0};
                    w_count_nxt = r_count - CNT_ONE;
                    w_ovf_nxt   = r_ovf | w_sign_change;
                end else begin
                    // One extra edge here makes a zero shift still take one cycle.
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and status decode straight from the state register
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == SHIFT);
    assign out_valid = (r_state == DONE);
    assign Y         = r_data;
    assign ovf       = r_ovf;

endmodule
